vector_shift_ctrl: RTL and testbench

VECTOR_SHIFT_CTRL -- requirements
Module: vector_shift_ctrl

---
 rtl/vshift_if.sv | 25 ++
 rtl/vector_shift_ctrl.sv | 88 ++++++++
 tb/tb_vector_shift_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vshift_if.sv
// vshift_if: issue/read/write bus between a vector shift requester and vector_shift_ctrl.
interface vshift_if;
  logic i_issue;
  logic [6:0] i_vl;
  logic [2:0] i_i;
  logic [2:0] i_j;
  logic o_ready;
  logic o_start;
  logic o_rd_en;
  logic [2:0] o_rd_vj;
  logic [5:0] o_rd_elem;
  logic o_wr_en;
  logic [2:0] o_wr_vi;
  logic [5:0] o_wr_elem;
  logic o_busy;
  logic o_done;
  modport master (
    output i_issue, i_vl, i_i, i_j,
    input o_ready, o_start, o_rd_en, o_rd_vj, o_rd_elem, o_wr_en, o_wr_vi, o_wr_elem, o_busy, o_done
  );
  modport slave (
    input i_issue, i_vl, i_i, i_j,
    output o_ready, o_start, o_rd_en, o_rd_vj, o_rd_elem, o_wr_en, o_wr_vi, o_wr_elem, o_busy, o_done
  );
endinterface

// File: rtl/vector_shift_ctrl.sv
// vector_shift_ctrl: sequences Vj element reads and LATENCY-delayed Vi writes for a vector shift.
// Optional VSHIFT_BACK2BACK_EN lets a new operation issue while the previous one drains.
module vector_shift_ctrl #(
  parameter int LATENCY = 4
) (
  input logic clk,
  input logic rst,
  vshift_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  localparam int DW = $clog2(LATENCY + 1);
  state_t state, state_nx;
  logic [6:0] n;
  logic [6:0] eff_vl;
  logic [5:0] cnt;
  logic [DW-1:0] dcnt;
  logic [2:0] vi, vj;
  logic accept, rd_en, rd_last, start;
  logic [LATENCY-1:0] pv, pl;
  logic [5:0] pe [LATENCY];
  logic [2:0] pi [LATENCY];
`ifdef VSHIFT_BACK2BACK_EN
  assign bus.o_ready = state == IDLE || state == DRAIN;
`else
  assign bus.o_ready = state == IDLE;
`endif
  assign accept = bus.i_issue & bus.o_ready;
  assign eff_vl = (bus.i_vl == 7'd0 || bus.i_vl > 7'd64) ? 7'd64 : bus.i_vl;
  assign rd_en = state == STREAM;
  assign rd_last = {1'b0, cnt} == n - 7'd1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = accept ? STREAM :
               state == STREAM ? (rd_last ? DRAIN : STREAM) :
               (state == DRAIN && dcnt == DW'(LATENCY - 1)) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      n <= 7'd0;
      vi <= 3'd0;
      vj <= 3'd0;
      cnt <= 6'd0;
      dcnt <= '0;
      start <= 1'b0;
    end else begin
      if (accept) begin
        n <= eff_vl;
        vi <= bus.i_i;
        vj <= bus.i_j;
      end
      cnt <= (rd_en && !rd_last) ? cnt + 6'd1 : 6'd0;
      dcnt <= state == DRAIN ? dcnt + DW'(1) : '0;
      start <= accept;
    end
  // Each pipeline slot carries its own Vi so overlapped operations write to the right register.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pv <= '0;
      pl <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        pe[k] <= 6'd0;
        pi[k] <= 3'd0;
      end
    end else begin
      pv[0] <= rd_en;
      pl[0] <= rd_en & rd_last;
      pe[0] <= cnt;
      pi[0] <= rd_en ? vi : 3'd0;
      for (int k = 1; k < LATENCY; k++) begin
        pv[k] <= pv[k-1];
        pl[k] <= pl[k-1];
        pe[k] <= pe[k-1];
        pi[k] <= pi[k-1];
      end
    end
  assign bus.o_start = start;
  assign bus.o_rd_en = rd_en;
  assign bus.o_rd_vj = rd_en ? vj : 3'd0;
  assign bus.o_rd_elem = rd_en ? cnt : 6'd0;
  assign bus.o_wr_en = pv[LATENCY-1];
  assign bus.o_wr_vi = pv[LATENCY-1] ? pi[LATENCY-1] : 3'd0;
  assign bus.o_wr_elem = pv[LATENCY-1] ? pe[LATENCY-1] : 6'd0;
  assign bus.o_busy = state != IDLE;
  assign bus.o_done = pv[LATENCY-1] & pl[LATENCY-1];
endmodule

// File: tb/tb_vector_shift_ctrl.sv
// tb_vector_shift_ctrl: random and directed issues checked against a per-cycle expectation table.
module tb_vector_shift_ctrl;
  localparam int LAT = 4;
  localparam int MAXC = 4096;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  vshift_if bus ();
  vector_shift_ctrl #(.LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bit e_start [MAXC];
  bit e_rd [MAXC];
  int e_rde [MAXC];
  int e_rdv [MAXC];
  bit e_wr [MAXC];
  int e_wre [MAXC];
  int e_wrv [MAXC];
  bit e_busy [MAXC];
  bit e_done [MAXC];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic bit model_ready(input int c);
`ifdef VSHIFT_BACK2BACK_EN
    return !e_rd[c];
`else
    return !e_busy[c];
`endif
  endfunction
  function automatic int eff(input int vl);
    return (vl == 0 || vl > 64) ? 64 : vl;
  endfunction
  task automatic schedule(input int t, input int n, input int vi, input int vj);
    e_start[t+1] = 1;
    for (int e = 0; e < n; e++) begin
      e_rd[t+1+e] = 1;
      e_rde[t+1+e] = e;
      e_rdv[t+1+e] = vj;
      e_wr[t+1+LAT+e] = 1;
      e_wre[t+1+LAT+e] = e;
      e_wrv[t+1+LAT+e] = vi;
    end
    for (int c = t + 1; c <= t + n + LAT; c++) e_busy[c] = 1;
    e_done[t+n+LAT] = 1;
  endtask
  task automatic clear_from(input int c0);
    for (int c = c0; c < MAXC; c++) begin
      e_start[c] = 0; e_rd[c] = 0; e_rde[c] = 0; e_rdv[c] = 0;
      e_wr[c] = 0; e_wre[c] = 0; e_wrv[c] = 0; e_busy[c] = 0; e_done[c] = 0;
    end
  endtask
  task automatic check_outputs();
    chk("ready", 32'(bus.o_ready), 32'(model_ready(cyc)));
    chk("start", 32'(bus.o_start), 32'(e_start[cyc]));
    chk("rd_en", 32'(bus.o_rd_en), 32'(e_rd[cyc]));
    chk("rd_elem", 32'(bus.o_rd_elem), 32'(e_rde[cyc]));
    chk("rd_vj", 32'(bus.o_rd_vj), 32'(e_rdv[cyc]));
    chk("wr_en", 32'(bus.o_wr_en), 32'(e_wr[cyc]));
    chk("wr_elem", 32'(bus.o_wr_elem), 32'(e_wre[cyc]));
    chk("wr_vi", 32'(bus.o_wr_vi), 32'(e_wrv[cyc]));
    chk("busy", 32'(bus.o_busy), 32'(e_busy[cyc]));
    chk("done", 32'(bus.o_done), 32'(e_done[cyc]));
  endtask
  task automatic step(input bit iss, input int vl, input int ii, input int jj);
    bus.i_issue = iss;
    bus.i_vl = 7'(vl);
    bus.i_i = 3'(ii);
    bus.i_j = 3'(jj);
    if (iss && rst && model_ready(cyc)) schedule(cyc, eff(vl), ii, jj);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask
  task automatic idle(input int k);
    for (int c = 0; c < k; c++) step(0, 0, 0, 0);
  endtask
  task automatic reset_pulse(input int k);
    #2 rst = 1'b0;
    #1 clear_from(cyc);
    check_outputs();
    idle(k);
    rst = 1'b1;
  endtask
  initial begin
    bus.i_issue = 0; bus.i_vl = 0; bus.i_i = 0; bus.i_j = 0;
    clear_from(0);
    @(negedge clk);
    check_outputs();
    idle(2);
    rst = 1'b1;
    step(1, 5, 3, 6);
    idle(12);
    step(1, 0, 7, 2);
    idle(72);
    step(1, 1, 4, 5);
    idle(8);
    step(1, 127, 2, 1);
    idle(70);
    for (int c = 0; c < 25; c++) step(1, 3, 5, 4);
    idle(10);
    step(1, 8, 6, 3);
    idle(2);
    reset_pulse(3);
    step(1, 5, 3, 6);
    idle(12);
    step(1, 64, 1, 7);
    reset_pulse(1);
    step(1, 2, 0, 0);
    idle(10);
`ifdef VSHIFT_BACK2BACK_EN
    step(1, 4, 1, 0);
    idle(4);
    step(1, 4, 2, 0);
    idle(12);
`endif
    for (int c = 0; c < 900; c++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 127), $urandom_range(0, 7), $urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) reset_pulse($urandom_range(1, 3));
    end
    idle(80);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
